// File: rtl/render_pkg.sv
// Shared types and helpers for the render scheduler slice.
package render_pkg;

  // Scheduler sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width of a slot index, never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/render_fb_if.sv
// Shared framebuffer write port.
// Handshake: drawing is the pixel-valid and oe the ready; a pixel (x, y, cidx)
// transfers in any cycle where drawing and oe are both high. The master holds
// drawing and the pixel stable until it sees oe high.
interface render_fb_if #(
  parameter int CORDW = 16,
  parameter int CIDXW = 4
);
  logic                    oe;
  logic signed [CORDW-1:0] x;
  logic signed [CORDW-1:0] y;
  logic [CIDXW-1:0]        cidx;
  logic                    drawing;

  modport master (input oe, output x, output y, output cidx, output drawing);
  modport slave  (output oe, input x, input y, input cidx, input drawing);
endinterface

// File: rtl/render_sched_next.sv
// Finds the lowest set bit of a mask at or above a start index.
module render_sched_next #(
  parameter int NREND = 4,
  parameter int IDXW  = 2
) (
  input  logic [NREND-1:0] i_mask,
  input  logic [IDXW:0]    i_from,
  output logic             o_found,
  output logic [IDXW-1:0]  o_idx
);

  // Scan downwards so the lowest qualifying bit is the last one written.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = NREND - 1; i >= 0; i--) begin
      if (i_mask[i] && (i >= int'(i_from))) begin
        o_found = 1'b1;
        o_idx   = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/render_scheduler.sv
// Runs each enabled renderer once per frame in ascending slot order and
// shares the framebuffer write port with whichever renderer is active.
module render_scheduler
  import render_pkg::*;
#(
  parameter int NREND = 4,
  parameter int CORDW = 16,
  parameter int CIDXW = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame,
  input  logic [NREND-1:0]              en_mask,
  render_fb_if.master                   fb,
  output logic [NREND-1:0]              r_start,
  output logic [NREND-1:0]              r_oe,
  input  logic [NREND*CORDW-1:0]        r_x,
  input  logic [NREND*CORDW-1:0]        r_y,
  input  logic [NREND*CIDXW-1:0]        r_cidx,
  input  logic [NREND-1:0]              r_drawing,
  input  logic [NREND-1:0]              r_done,
  output logic [idx_w(NREND)-1:0]       cur,
  output logic                          busy,
  output logic                          done,
  output logic                          overrun,
  output state_t                        o_dbg_state
);

  localparam int IDXW = idx_w(NREND);

  state_t           r_state;
  logic [NREND-1:0] r_mask;
  logic [IDXW-1:0]  r_cur;
  logic [NREND-1:0] r_start_q;
  logic             r_done_q;
  logic             r_overrun_q;

  logic [NREND-1:0] w_search_mask;
  logic [IDXW:0]    w_from;
  logic             w_found;
  logic [IDXW-1:0]  w_idx;

  // In IDLE the first slot comes from the incoming mask; afterwards the
  // successor search runs over the latched mask above the current slot.
  assign w_search_mask = (r_state == IDLE) ? en_mask : r_mask;
  assign w_from        = (r_state == IDLE) ? '0
                       : ({1'b0, r_cur} + {{IDXW{1'b0}}, 1'b1});

  render_sched_next #(
    .NREND (NREND),
    .IDXW  (IDXW)
  ) u_next (
    .i_mask  (w_search_mask),
    .i_from  (w_from),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  // Sequencing FSM with registered start/done/overrun pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mask      <= '0;
      r_cur       <= '0;
      r_start_q   <= '0;
      r_done_q    <= 1'b0;
      r_overrun_q <= 1'b0;
    end else begin
      r_start_q   <= '0;
      r_done_q    <= 1'b0;
      r_overrun_q <= frame && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (frame) begin
            r_mask <= en_mask;
            if (w_found) begin
              r_cur     <= w_idx;
              r_start_q <= NREND'(1) << w_idx;
              r_state   <= START;
            end else begin
              r_done_q <= 1'b1;
              r_state  <= DONE;
            end
          end
        end
        START: r_state <= WAIT;
        WAIT: begin
          if (r_done[r_cur]) begin
            if (w_found) begin
              r_cur     <= w_idx;
              r_start_q <= NREND'(1) << w_idx;
              r_state   <= START;
            end else begin
              r_done_q <= 1'b1;
              r_state  <= DONE;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Only the active renderer sees backpressure and only its pixel is valid.
  always_comb begin
    r_oe       = '0;
    fb.drawing = 1'b0;
    if (r_state == WAIT) begin
      r_oe[r_cur] = fb.oe;
      fb.drawing  = r_drawing[r_cur];
    end
  end

  assign fb.x    = r_x[int'(r_cur)*CORDW +: CORDW];
  assign fb.y    = r_y[int'(r_cur)*CORDW +: CORDW];
  assign fb.cidx = r_cidx[int'(r_cur)*CIDXW +: CIDXW];

  assign r_start     = r_start_q;
  assign done        = r_done_q;
  assign overrun     = r_overrun_q;
  assign cur         = r_cur;
  assign busy        = (r_state != IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: doc/render_scheduler.md
Name: render_scheduler

Overview:
- Sequences up to NREND render modules (render_teleport-style: start/oe/x/y/cidx/drawing/done) through one frame of drawing.
- Shares the single framebuffer write port between them.
- Sits between the frame-timing logic and the framebuffer: once per frame it starts each enabled renderer in turn, in ascending index order.
- Forwards framebuffer backpressure only to the active renderer and muxes that renderer's pixel output onto the shared port.

Parameters:
- NREND, 4, number of renderer slots (1-8).
- CORDW, 16, signed coordinate width (bits).
- CIDXW, 4, colour index width (bits).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- frame  input  1  start-of-frame pulse, one cycle.
- en_mask  input  NREND  renderer enable mask, sampled on an accepted frame.
- oe  input  1  framebuffer can accept a pixel this cycle.
- r_start  output  NREND  one-hot start pulse to each renderer.
- r_oe  output  NREND  per-renderer output enable.
- r_x  input  NREND*CORDW  flattened renderer x (slot i at [i*CORDW +: CORDW]).
- r_y  input  NREND*CORDW  flattened renderer y.
- r_cidx  input  NREND*CIDXW  flattened renderer colour index.
- r_drawing  input  NREND  renderer pixel-valid.
- r_done  input  NREND  renderer done pulses.
- x  output  CORDW  signed shared draw x.
- y  output  CORDW  signed shared draw y.
- cidx  output  CIDXW  shared colour index.
- drawing  output  1  shared pixel-valid.
- cur  output  $clog2(NREND) (min 1)  active slot index.
- busy  output  1  scheduler mid-frame.
- done  output  1  frame complete; high one cycle.
- overrun  output  1  frame arrived while busy; high one cycle.

Behaviour:
- States: IDLE, START, WAIT, DONE.
- Reset values: state IDLE, cur 0, mask register 0, r_start 0, done 0, overrun 0, busy 0, drawing 0.
- IDLE, frame=1 at cycle t:
  - Register en_mask.
  - If mask is nonzero: cur <= lowest set bit, go to START. r_start[cur] is high in cycle t+1 only.
  - If mask is zero: go to DONE; done is high at t+1.
- START: always goes to WAIT in the next cycle.
- WAIT:
  - r_oe[cur] = oe. All other r_oe bits are 0.
  - x/y/cidx are muxed combinationally from slot cur. drawing = r_drawing[cur].
  - On r_done[cur] at cycle u: if a higher set bit exists in the registered mask, cur <= that bit, go to START (r_start at u+1). Otherwise go to DONE (done=1 at u+1).
- DONE: done=1 for one cycle, then IDLE. No new frame is accepted in the DONE cycle itself.
- Outside WAIT: r_oe=0, drawing=0, x/y/cidx hold the slot-cur mux value (don't-care).
- busy = (state != IDLE).
- frame while busy (START/WAIT/DONE): frame is ignored, overrun=1 in the next cycle, and the sequence continues unchanged.
- r_done from a non-active slot is ignored. r_drawing from non-active slots is never forwarded.
- en_mask changes mid-frame have no effect until the next accepted frame.
- oe low in WAIT: the renderer stalls; the scheduler adds no timeout.
- rst mid-frame: return to IDLE with all outputs at reset values in the next cycle. Renderers share rst.
- Simultaneous rst and frame: rst wins; the frame is dropped and no overrun is raised.
- Scheduler overhead: 2 cycles per enabled renderer (START plus the done-to-next transition) plus 1 cycle for DONE.

Decomposition:
- Shared package render_pkg: state enum (IDLE, START, WAIT, DONE) and the slot index width function.
- One sub-module, render_sched_next: combinational "next set bit above index" finder over the registered mask, returning a found flag and an index. Used both for the first slot (search from -1) and for successor selection.

Test Plan:
- NREND=4, en_mask=4'b1011, frame at t:
  - r_start sequence is slot 0 at t+1, then slot 1, then slot 3; slot 2 never starts.
  - done fires once, 1 cycle after r_done[3].
- en_mask=0, frame at t -> done=1 at t+1, r_start stays 0, busy high only at t+1.
- Slot 1 active, oe toggling 1,0,1:
  - r_oe = 4'b0010 masked by oe.
  - drawing/x/y/cidx equal slot 1's values.
  - Slot 0 driving r_drawing=1 does not appear on the output.
- frame pulsed again during WAIT -> overrun=1 next cycle; sequence completes normally; exactly one done.
- rst asserted in WAIT with slot 2 active -> next cycle: IDLE, r_oe=0, drawing=0, busy=0; no done pulse.
- Spurious r_done[2] while slot 0 active -> ignored; cur stays 0 until r_done[0].
